spi_initiator: RTL and testbench

- Synthesizable SPI mode-0 (CPOL=0, CPHA=0) master, MSB first; drives sck, sdo and csn[3:0] from one system clock.
- Accepts one word per valid/ready request, shifts it out on sdo while shifting sdi in, and returns the received word on a one-cycle response strobe.
- Sits between a test/control sequencer and one or more SPI targets (spi_target_bfm-compatible); csn[0] selects the first target.

---
 rtl/spi_initiator.sv | 137 +++++++++++++
 tb/tb_spi_initiator.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_initiator.sv
// SPI mode-0 (CPOL=0, CPHA=0) initiator, MSB first.
// One word is accepted per valid/ready handshake. The word is shifted out on
// sdo while sdi is shifted in. The received word is returned with a
// single-cycle rsp_valid strobe. A chip select can be held across words
// (keep flag) and dropped later with cs_release.
module spi_initiator #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 2,
  parameter int NUM_CS     = 4,
  localparam int CS_W      = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DATA_WIDTH-1:0] req_data,
  input  logic [CS_W-1:0]       req_cs,
  input  logic                  req_keep_cs,
  input  logic                  cs_release,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  sck,
  output logic                  sdo,
  input  logic                  sdi,
  output logic [NUM_CS-1:0]     csn
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } state_t;

  localparam int              BIT_W      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [7:0]      DIV_RELOAD = 8'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_WIDTH - 1);
  localparam logic [NUM_CS-1:0] CS_IDLE  = {NUM_CS{1'b1}};

  state_t                state;
  logic [7:0]            div_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] tx_shift;
  logic [DATA_WIDTH-1:0] rx_shift;
  logic                  keep;

  logic [DATA_WIDTH-1:0] tx_next;
  logic [DATA_WIDTH-1:0] rx_next;
  logic [NUM_CS-1:0]     cs_sel;

  // Next shift-register values and the active-low select for the request.
  always_comb begin
    tx_next = tx_shift << 1;
    rx_next = (rx_shift << 1) | DATA_WIDTH'(sdi);
    cs_sel  = ~(NUM_CS'(1) << req_cs);
  end

  // Transfer sequencer: IDLE waits for a request; LOW and HIGH each last
  // CLK_DIV cycles and form one sck period per bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      div_cnt   <= 8'd0;
      bit_cnt   <= '0;
      tx_shift  <= '0;
      rx_shift  <= '0;
      keep      <= 1'b0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      sck       <= 1'b0;
      sdo       <= 1'b0;
      csn       <= CS_IDLE;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          // A request takes priority over a same-cycle cs_release.
          if (req_valid) begin
            tx_shift  <= req_data;
            sdo       <= req_data[DATA_WIDTH-1];
            keep      <= req_keep_cs;
            csn       <= cs_sel;
            sck       <= 1'b0;
            req_ready <= 1'b0;
            div_cnt   <= DIV_RELOAD;
            bit_cnt   <= '0;
            state     <= LOW;
          end else if (cs_release) begin
            csn <= CS_IDLE;
          end
        end
        LOW: begin
          if (div_cnt == 8'd0) begin
            // Rising sck edge: target data is stable, capture it.
            sck      <= 1'b1;
            rx_shift <= rx_next;
            div_cnt  <= DIV_RELOAD;
            state    <= HIGH;
          end else begin
            div_cnt <= div_cnt - 8'd1;
          end
        end
        HIGH: begin
          if (div_cnt == 8'd0) begin
            sck <= 1'b0;
            if (bit_cnt == LAST_BIT) begin
              // Last falling edge: report the word and go idle. sdo keeps
              // the last transmitted bit.
              rsp_valid <= 1'b1;
              rsp_data  <= rx_shift;
              req_ready <= 1'b1;
              state     <= IDLE;
              if (!keep) begin
                csn <= CS_IDLE;
              end
            end else begin
              // Falling edge mid-word: present the next bit.
              tx_shift <= tx_next;
              sdo      <= tx_next[DATA_WIDTH-1];
              bit_cnt  <= bit_cnt + BIT_W'(1);
              div_cnt  <= DIV_RELOAD;
              state    <= LOW;
            end
          end else begin
            div_cnt <= div_cnt - 8'd1;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          sck       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_initiator.sv
// Self-checking bench for spi_initiator: a driver issues requests and pushes
// the expected transfer into a scoreboard queue; a monitor thread rebuilds
// the transmitted word from sdo at each sck rise and checks every response.
module tb_spi_initiator;

  localparam int DW = 8;
  localparam int CD = 2;
  localparam int NC = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [DW-1:0] req_data = '0;
  logic [1:0]   req_cs = 2'd0;
  logic         req_keep_cs = 1'b0;
  logic         cs_release = 1'b0;
  logic         rsp_valid;
  logic [DW-1:0] rsp_data;
  logic         sck;
  logic         sdo;
  logic         sdi;
  logic [NC-1:0] csn;

  spi_initiator #(.DATA_WIDTH(DW), .CLK_DIV(CD), .NUM_CS(NC)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_cs(req_cs), .req_keep_cs(req_keep_cs),
    .cs_release(cs_release), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .sck(sck), .sdo(sdo), .sdi(sdi), .csn(csn)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Target model: presents the response word MSB first, advancing on each
  // falling sck edge since the transfer was issued.
  int           sck_falls = 0;
  int           tgt_base = 0;
  logic [DW-1:0] tgt_word = '0;
  int           tgt_idx;
  always @(negedge sck) sck_falls <= sck_falls + 1;
  always_comb begin
    tgt_idx = sck_falls - tgt_base;
    if (tgt_idx >= 0 && tgt_idx < DW) sdi = tgt_word[3'(DW - 1 - tgt_idx)];
    else sdi = 1'b0;
  end

  typedef struct {
    logic [DW-1:0] tx;
    logic [DW-1:0] rx;
    int            cs;
    bit            keep;
    int            acc;
  } exp_t;

  exp_t exp_q[$];
  int   rsp_cycles[$];
  int   n_tests = 0;
  int   n_fail = 0;

  function automatic logic [NC-1:0] cs_vec(input int cs);
    logic [NC-1:0] one;
    one = 4'b0001;
    return ~(one << cs);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: collects sdo at sck rises and checks each rsp_valid pulse.
  task automatic monitor();
    logic          prev_sck;
    logic          prev_rsp;
    logic [DW-1:0] bits;
    int            nb;
    exp_t          e;
    prev_sck = 1'b0; prev_rsp = 1'b0; bits = '0; nb = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_sck = 1'b0; prev_rsp = 1'b0; bits = '0; nb = 0;
      end else begin
        if (sck && !prev_sck) begin
          bits = {bits[DW-2:0], sdo};
          nb++;
          if (exp_q.size() > 0) chk("csn_during_xfer", 32'(csn), 32'(cs_vec(exp_q[0].cs)));
        end
        if (rsp_valid) begin
          chk("rsp_single_cycle", 32'(prev_rsp), 32'd0);
          if (exp_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_rsp: got rsp_valid with data 0x%0h, required none, cycle %0d", rsp_data, cyc);
          end else begin
            e = exp_q.pop_front();
            chk("rsp_data", 32'(rsp_data), 32'(e.rx));
            chk("sdo_word", 32'(bits), 32'(e.tx));
            chk("sck_pulses", 32'(nb), 32'(DW));
            chk("rsp_latency", 32'(cyc), 32'(e.acc + 2 * DW * CD));
            chk("csn_at_done", 32'(csn), 32'(e.keep ? cs_vec(e.cs) : 4'b1111));
          end
          rsp_cycles.push_back(cyc);
          bits = '0; nb = 0;
        end
        prev_sck = sck;
        prev_rsp = rsp_valid;
      end
    end
  endtask

  // Drive one request; returns #1 after the accepting edge with valid low.
  task automatic issue(input logic [DW-1:0] d, input int cs, input bit keep,
                       input logic [DW-1:0] w, input bit push_exp, output int acc);
    int guard;
    guard = 0;
    acc = -1;
    @(negedge clk);
    req_valid = 1'b1; req_data = d; req_cs = 2'(cs); req_keep_cs = keep;
    while (!req_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
    end else begin
      tgt_word = w;
      tgt_base = sck_falls;
      acc = cyc + 1;
      if (push_exp) exp_q.push_back('{tx: d, rx: w, cs: cs, keep: keep, acc: acc});
      @(posedge clk);
      #1;
      req_valid = 1'b0;
    end
  endtask

  task automatic wait_done();
    int guard;
    guard = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || !req_ready) && guard < 600) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0 || !req_ready) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int acc;
    int nrsp;
    fork
      monitor();
    join_none

    // Reset state.
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset_csn", 32'(csn), 32'hF);
    chk("reset_sck", 32'(sck), 32'd0);
    chk("reset_sdo", 32'(sdo), 32'd0);
    chk("reset_ready", 32'(req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_data", 32'(rsp_data), 32'd0);

    // Basic word to cs 0.
    issue(8'hA5, 0, 1'b0, 8'h3C, 1'b1, acc);
    chk("a5_csn_start", 32'(csn), 32'hE);
    chk("a5_sdo_msb", 32'(sdo), 32'd1);
    chk("a5_ready_low", 32'(req_ready), 32'd0);
    wait_done();
    chk("a5_csn_after", 32'(csn), 32'hF);

    // Held chip select across two words on cs 2.
    issue(8'h12, 2, 1'b1, 8'h9C, 1'b1, acc);
    issue(8'h34, 2, 1'b0, 8'h61, 1'b1, acc);
    wait_done();
    chk("keep_csn_after", 32'(csn), 32'hF);

    // Held cs 1, then cs_release in idle.
    issue(8'h77, 1, 1'b1, 8'h88, 1'b1, acc);
    wait_done();
    chk("held_cs1", 32'(csn), 32'hD);
    cs_release = 1'b1;
    @(negedge clk);
    cs_release = 1'b0;
    chk("released_cs1", 32'(csn), 32'hF);

    // cs_release in the same cycle as a request: request wins.
    issue(8'h0F, 1, 1'b1, 8'hF0, 1'b1, acc);
    wait_done();
    cs_release = 1'b1;
    issue(8'hC3, 1, 1'b0, 8'h5A, 1'b1, acc);
    cs_release = 1'b0;
    chk("release_vs_req_csn", 32'(csn), 32'hD);
    chk("release_vs_req_busy", 32'(req_ready), 32'd0);
    wait_done();

    // Held cs 0 switching straight to cs 3.
    issue(8'h81, 0, 1'b1, 8'h42, 1'b1, acc);
    wait_done();
    chk("switch_before", 32'(csn), 32'hE);
    issue(8'h18, 3, 1'b0, 8'h24, 1'b1, acc);
    chk("switch_after", 32'(csn), 32'h7);
    wait_done();

    // Back-to-back: second word accepted the cycle after the first response.
    nrsp = rsp_cycles.size();
    issue(8'hFF, 0, 1'b0, 8'hFF, 1'b1, acc);
    issue(8'h00, 0, 1'b0, 8'hFF, 1'b1, acc);
    wait_done();
    chk("b2b_rsp_count", 32'(rsp_cycles.size() - nrsp), 32'd2);
    if (rsp_cycles.size() - nrsp == 2)
      chk("b2b_gap", 32'(rsp_cycles[nrsp + 1] - rsp_cycles[nrsp]), 32'(1 + 2 * DW * CD));

    // Reset during bit 3 aborts the transfer without a response.
    nrsp = rsp_cycles.size();
    issue(8'h5A, 1, 1'b0, 8'hA5, 1'b0, acc);
    while (cyc < acc + CD + 6 * CD) @(negedge clk);
    chk("abort_in_bit3_sck", 32'(sck), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_csn", 32'(csn), 32'hF);
    chk("abort_sck", 32'(sck), 32'd0);
    chk("abort_sdo", 32'(sdo), 32'd0);
    chk("abort_ready", 32'(req_ready), 32'd1);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("abort_no_rsp", 32'(rsp_cycles.size() - nrsp), 32'd0);

    // Randomized traffic, with cs_release toggled while busy.
    for (int i = 0; i < 24; i++) begin
      cs_release = 1'($urandom_range(0, 1));
      issue(8'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            8'($urandom), 1'b1, acc);
      cs_release = 1'b0;
      if ($urandom_range(0, 2) == 0) wait_done();
    end
    wait_done();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
